// File: rtl/multi_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_timer_pkg
// Description : Shared types, register offsets and CTRL bit positions for the
//               multi-channel timer.
// Revision    : 1.0
// ============================================================================
package multi_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RELOAD = 2'd2
    } chan_state_e;

    // Global register offsets
    localparam int c_off_div   = 0;
    localparam int c_off_iflag = 1;

    // Per-channel register offsets within one channel window
    localparam int c_off_cnt   = 0;
    localparam int c_off_mod   = 1;
    localparam int c_off_ctrl  = 2;
    localparam int c_ch_base   = 4;
    localparam int c_ch_stride = 4;

    // CTRL register bit positions
    localparam int c_ctrl_sel_lsb = 0;
    localparam int c_ctrl_sel_msb = 1;
    localparam int c_ctrl_en      = 2;
    localparam int c_ctrl_oneshot = 3;

    function automatic int ch_addr(input int ch, input int off);
        return c_ch_base + c_ch_stride * ch + off;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_timer_if
// Description : CPU I/O register bus and interrupt lines of the timer block.
// Revision    : 1.0
// ============================================================================
interface multi_timer_if #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [N_CH-1:0]   irq;
    logic              irq_any;

    modport master (
        output addr, wr, rd, wdata,
        input  rdata, irq, irq_any
    );

    modport slave (
        input  addr, wr, rd, wdata,
        output rdata, irq, irq_any
    );
endinterface
`default_nettype wire

// File: rtl/multi_timer_chan.sv
`default_nettype none
// ============================================================================
// Module      : multi_timer_chan
// Description : One reloadable timer channel: CNT/MOD/CTRL, tap edge detect
//               and the IDLE/RUN/RELOAD sequencer.
// Revision    : 1.0
// ============================================================================
module multi_timer_chan
    import multi_timer_pkg::*;
#(
    parameter int              DATA_W = 8,
    parameter int              DIV_W  = 16,
    parameter logic [3:0][7:0] TAPS   = {8'd9, 8'd7, 8'd5, 8'd3}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  i_div,
    input  logic              i_wr_cnt,
    input  logic              i_wr_mod,
    input  logic              i_wr_ctrl,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_cnt,
    output logic [DATA_W-1:0] o_mod,
    output logic [DATA_W-1:0] o_ctrl,
    output logic              o_irq_set
);

    chan_state_e       r_state;
    chan_state_e       w_state_nxt;
    logic [DATA_W-1:0] r_cnt;
    logic [DATA_W-1:0] w_cnt_nxt;
    logic [DATA_W-1:0] r_mod;
    logic [1:0]        r_sel;
    logic              r_en;
    logic              r_oneshot;
    logic              r_src_prev;
    logic [DIV_W-1:0]  w_div_sh;
    logic              w_src;
    logic              w_tick;
    logic              w_oneshot_done;

    // Falling edge of the gated tap; gating by en is what makes clearing en
    // (or moving the tap / clearing DIV) while the tap is high produce a tick.
    assign w_div_sh = i_div >> TAPS[r_sel];
    assign w_src    = w_div_sh[0] & r_en;
    assign w_tick   = r_src_prev & ~w_src;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_oneshot_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_wr_cnt) begin
                    w_cnt_nxt = i_wdata;
                end
                if (r_en) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (i_wr_cnt) begin
                    w_cnt_nxt = i_wdata;
                    if (!r_en) begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_tick && (r_cnt == {DATA_W{1'b1}})) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RELOAD;
                end else begin
                    if (w_tick) begin
                        w_cnt_nxt = r_cnt + DATA_W'(1);
                    end
                    if (!r_en) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            RELOAD: begin
                // A MOD write landing here is forwarded straight into CNT.
                w_cnt_nxt      = i_wr_mod ? i_wdata : r_mod;
                w_oneshot_done = r_oneshot;
                w_state_nxt    = (r_oneshot || !r_en) ? IDLE : RUN;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_mod      <= '0;
            r_sel      <= '0;
            r_en       <= 1'b0;
            r_oneshot  <= 1'b0;
            r_src_prev <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_src_prev <= w_src;
            if (i_wr_mod) begin
                r_mod <= i_wdata;
            end
            if (i_wr_ctrl) begin
                r_sel     <= i_wdata[c_ctrl_sel_msb:c_ctrl_sel_lsb];
                r_en      <= i_wdata[c_ctrl_en];
                r_oneshot <= i_wdata[c_ctrl_oneshot];
            end
            if (w_oneshot_done) begin
                r_en <= 1'b0;
            end
        end
    end

    always_comb begin
        o_ctrl                                 = '0;
        o_ctrl[c_ctrl_sel_msb:c_ctrl_sel_lsb]  = r_sel;
        o_ctrl[c_ctrl_en]                      = r_en;
        o_ctrl[c_ctrl_oneshot]                 = r_oneshot;
    end

    assign o_cnt     = r_cnt;
    assign o_mod     = r_mod;
    assign o_irq_set = (r_state == RELOAD);

endmodule
`default_nettype wire

// File: rtl/multi_timer.sv
`default_nettype none
// ============================================================================
// Module      : multi_timer
// Description : Free-running divider feeding N_CH reloadable timer channels,
//               with IFLAG interrupt register and CPU register read mux.
// Revision    : 1.0
// ============================================================================
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int              N_CH   = 2,
    parameter int              DATA_W = 8,
    parameter int              DIV_W  = 16,
    parameter int              ADDR_W = 6,
    parameter logic [3:0][7:0] TAPS   = {8'd9, 8'd7, 8'd5, 8'd3}
) (
    input  logic          clk,
    input  logic          reset,
    multi_timer_if.slave  bus
);

    logic [DIV_W-1:0]  r_div;
    logic [N_CH-1:0]   r_irq;
    logic [N_CH-1:0]   w_irq_set;
    logic [N_CH-1:0]   w_clr;
    logic [DATA_W-1:0] w_irq_rd;
    logic [DATA_W-1:0] w_rdata;
    logic              w_wr_div;
    logic              w_wr_iflag;
    logic [N_CH-1:0]   w_wr_cnt;
    logic [N_CH-1:0]   w_wr_mod;
    logic [N_CH-1:0]   w_wr_ctrl;
    logic [DATA_W-1:0] w_cnt  [N_CH];
    logic [DATA_W-1:0] w_mod  [N_CH];
    logic [DATA_W-1:0] w_ctrl [N_CH];

    assign w_wr_div   = bus.wr && (bus.addr == ADDR_W'(c_off_div));
    assign w_wr_iflag = bus.wr && (bus.addr == ADDR_W'(c_off_iflag));

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        assign w_wr_cnt[gi]  = bus.wr && (bus.addr == ADDR_W'(ch_addr(gi, c_off_cnt)));
        assign w_wr_mod[gi]  = bus.wr && (bus.addr == ADDR_W'(ch_addr(gi, c_off_mod)));
        assign w_wr_ctrl[gi] = bus.wr && (bus.addr == ADDR_W'(ch_addr(gi, c_off_ctrl)));

        multi_timer_chan #(
            .DATA_W (DATA_W),
            .DIV_W  (DIV_W),
            .TAPS   (TAPS)
        ) u_chan (
            .clk       (clk),
            .rst       (reset),
            .i_div     (r_div),
            .i_wr_cnt  (w_wr_cnt[gi]),
            .i_wr_mod  (w_wr_mod[gi]),
            .i_wr_ctrl (w_wr_ctrl[gi]),
            .i_wdata   (bus.wdata),
            .o_cnt     (w_cnt[gi]),
            .o_mod     (w_mod[gi]),
            .o_ctrl    (w_ctrl[gi]),
            .o_irq_set (w_irq_set[gi])
        );
    end

    // IFLAG is only as wide as the data bus can address; higher flags cannot be cleared.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_clr
        if (gi < DATA_W) begin : g_map
            assign w_clr[gi] = w_wr_iflag & bus.wdata[gi];
        end else begin : g_none
            assign w_clr[gi] = 1'b0;
        end
    end

    for (genvar gj = 0; gj < DATA_W; gj++) begin : g_irq_rd
        if (gj < N_CH) begin : g_map
            assign w_irq_rd[gj] = r_irq[gj];
        end else begin : g_none
            assign w_irq_rd[gj] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
            r_irq <= '0;
        end else begin
            r_div <= w_wr_div ? '0 : r_div + DIV_W'(1);
            r_irq <= (r_irq & ~w_clr) | w_irq_set;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (bus.rd) begin
            if (bus.addr == ADDR_W'(c_off_div)) begin
                w_rdata = r_div[DIV_W-1 -: DATA_W];
            end
            if (bus.addr == ADDR_W'(c_off_iflag)) begin
                w_rdata = w_irq_rd;
            end
            for (int c = 0; c < N_CH; c++) begin
                if (bus.addr == ADDR_W'(ch_addr(c, c_off_cnt))) begin
                    w_rdata = w_cnt[c];
                end
                if (bus.addr == ADDR_W'(ch_addr(c, c_off_mod))) begin
                    w_rdata = w_mod[c];
                end
                if (bus.addr == ADDR_W'(ch_addr(c, c_off_ctrl))) begin
                    w_rdata = w_ctrl[c];
                end
            end
        end
    end

    assign bus.rdata   = w_rdata;
    assign bus.irq     = r_irq;
    assign bus.irq_any = |r_irq;

endmodule
`default_nettype wire

// File: tb/tb_multi_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_timer
// Description : Self-checking bench for multi_timer: directed scenarios with
//               literal expectations plus randomized traffic vs. a model.
// Revision    : 1.0
// ============================================================================
module tb_multi_timer;

    localparam int N_CH   = 2;
    localparam int DATA_W = 8;
    localparam int DIV_W  = 16;
    localparam int ADDR_W = 6;
    localparam int M_TAP [4] = '{3, 5, 7, 9};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    multi_timer_if #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    multi_timer #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural reference: register contents plus "counting" and
    // "reload pending" flags per channel, advanced once per clock.
    // ------------------------------------------------------------------
    int m_div, m_irq;
    int m_cnt [N_CH];
    int m_mod [N_CH];
    int m_sel [N_CH];
    bit m_en  [N_CH];
    bit m_os  [N_CH];
    bit m_prev[N_CH];
    bit m_run [N_CH];
    bit m_rel [N_CH];

    always @(posedge clk) begin : model
        int set_mask, clr, a, d;
        bit w, src, tick, wcnt, wmod, wctl, done;
        if (reset) begin
            m_div = 0;
            m_irq = 0;
            for (int c = 0; c < N_CH; c++) begin
                m_cnt[c] = 0; m_mod[c] = 0; m_sel[c] = 0; m_en[c] = 0;
                m_os[c] = 0; m_prev[c] = 0; m_run[c] = 0; m_rel[c] = 0;
            end
        end else begin
            w = bus.wr;
            a = int'(bus.addr);
            d = int'(bus.wdata);
            set_mask = 0;
            for (int c = 0; c < N_CH; c++) begin
                src  = (((m_div >> M_TAP[m_sel[c]]) & 1) == 1) && m_en[c];
                tick = m_prev[c] && !src;
                m_prev[c] = src;
                wcnt = w && (a == 4 + 4 * c);
                wmod = w && (a == 5 + 4 * c);
                wctl = w && (a == 6 + 4 * c);
                done = 0;
                if (m_rel[c]) begin
                    m_cnt[c] = wmod ? d : m_mod[c];
                    set_mask |= (1 << c);
                    m_rel[c] = 0;
                    m_run[c] = !(m_os[c] || !m_en[c]);
                    done = m_os[c];
                end else if (m_run[c]) begin
                    if (wcnt) m_cnt[c] = d;
                    else if (tick) begin
                        if (m_cnt[c] == 255) begin
                            m_cnt[c] = 0;
                            m_rel[c] = 1;
                            m_run[c] = 0;
                        end else begin
                            m_cnt[c] = m_cnt[c] + 1;
                        end
                    end
                    if (!m_rel[c] && !m_en[c]) m_run[c] = 0;
                end else begin
                    if (wcnt) m_cnt[c] = d;
                    if (m_en[c]) m_run[c] = 1;
                end
                if (wmod) m_mod[c] = d;
                if (wctl) begin
                    m_sel[c] = d & 3;
                    m_en[c]  = ((d >> 2) & 1) == 1;
                    m_os[c]  = ((d >> 3) & 1) == 1;
                end
                if (done) m_en[c] = 0;
            end
            clr   = (w && a == 1) ? (d & ((1 << N_CH) - 1)) : 0;
            m_irq = (m_irq & ~clr) | set_mask;
            m_div = (w && a == 0) ? 0 : ((m_div + 1) & 16'hFFFF);
        end
    end

    function automatic int m_read(input int a);
        if (a == 0) return (m_div >> 8) & 255;
        if (a == 1) return m_irq;
        for (int c = 0; c < N_CH; c++) begin
            if (a == 4 + 4 * c) return m_cnt[c];
            if (a == 5 + 4 * c) return m_mod[c];
            if (a == 6 + 4 * c) return m_sel[c] | (int'(m_en[c]) << 2) | (int'(m_os[c]) << 3);
        end
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("irq", 32'(bus.irq), 32'(m_irq));
        check("irq_any", 32'(bus.irq_any), 32'(m_irq != 0));
        check("rdata", 32'(bus.rdata), bus.rd ? 32'(m_read(int'(bus.addr))) : 32'd0);
    end

    // ------------------------------------------------------------------
    // Bus helpers; all driving happens 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_reg(input int a, input int d);
        bus.addr  = ADDR_W'(a);
        bus.wdata = DATA_W'(d);
        bus.wr    = 1'b1;
        step(1);
        bus.wr    = 1'b0;
    endtask

    task automatic rd_chk(input string name, input int a, input int exp);
        bus.addr = ADDR_W'(a);
        bus.rd   = 1'b1;
        #1;
        check(name, 32'(bus.rdata), 32'(exp));
        bus.rd   = 1'b0;
    endtask

    task automatic do_reset();
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        reset  = 1'b1;
        step(3);
        reset  = 1'b0;
    endtask

    // ch0: MOD=CNT=0xFE, sel=1, en; then DIV cleared (reference point n=0)
    task automatic setup_ch0();
        wr_reg(5, 'hFE);
        wr_reg(4, 'hFE);
        wr_reg(6, 'h05);
    endtask

    initial begin
        int base;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.wr    = 1'b0;
        bus.rd    = 1'b0;

        // Register sweep while held in reset
        reset = 1'b1;
        step(2);
        for (int a = 0; a < 64; a++) begin
            rd_chk("reset_read", a, 0);
            step(1);
        end
        check("reset_irq_any", 32'(bus.irq_any), 32'd0);
        do_reset();
        rd_chk("unmapped_3f", 'h3F, 0);

        // Periodic overflow and reload
        setup_ch0();
        wr_reg(0, 0);
        step(64);  rd_chk("a_cnt_64", 4, 'hFE);
        step(1);   rd_chk("a_cnt_65", 4, 'hFF);
        step(63);  rd_chk("a_cnt_128", 4, 'hFF);
        step(1);   rd_chk("a_cnt_129", 4, 'h00);
        step(1);   rd_chk("a_cnt_130", 4, 'hFE);
        check("a_irq_130", 32'(bus.irq), 32'd1);
        wr_reg(1, 1);
        check("a_irq_clr", 32'(bus.irq), 32'd0);
        step(127); rd_chk("a_cnt_258", 4, 'hFE);
        check("a_irq_258", 32'(bus.irq), 32'd1);

        // CNT write in the overflow cycle cancels the reload
        do_reset();
        setup_ch0();
        wr_reg(0, 0);
        step(128);
        wr_reg(4, 'h10);
        rd_chk("b_cnt_129", 4, 'h10);
        step(1);   rd_chk("b_cnt_130", 4, 'h10);
        check("b_irq_130", 32'(bus.irq), 32'd0);

        // CNT write in the RELOAD cycle loses to the reload
        do_reset();
        setup_ch0();
        wr_reg(0, 0);
        step(129);
        wr_reg(4, 'h10);
        rd_chk("c_cnt_130", 4, 'hFE);
        check("c_irq_130", 32'(bus.irq), 32'd1);

        // One-shot on ch1 with the slowest tap
        do_reset();
        wr_reg(9, 'h33);
        wr_reg(8, 'hFF);
        wr_reg(10, 'h0F);
        wr_reg(0, 0);
        step(1025); rd_chk("d_cnt_1025", 8, 'h00);
        step(1);    rd_chk("d_cnt_1026", 8, 'h33);
        rd_chk("d_ctrl_1026", 10, 'h0B);
        check("d_irq_1026", 32'(bus.irq), 32'd2);
        wr_reg(1, 2);
        step(1100); rd_chk("d_cnt_late", 8, 'h33);
        check("d_irq_late", 32'(bus.irq), 32'd0);

        // Glitch ticks from DIV write and from clearing en
        do_reset();
        wr_reg(6, 'h04);
        wr_reg(4, 'h20);
        for (int k = 0; k < 32 && ((m_div & 15) != 10); k++) step(1);
        base = m_cnt[0];
        wr_reg(0, 0);
        rd_chk("e_div_glitch_0", 4, base);
        step(1); rd_chk("e_div_glitch_1", 4, (base + 1) & 255);
        for (int k = 0; k < 32 && ((m_div & 15) != 10); k++) step(1);
        base = m_cnt[0];
        wr_reg(6, 'h00);
        rd_chk("e_en_glitch_0", 4, base);
        step(1);  rd_chk("e_en_glitch_1", 4, (base + 1) & 255);
        step(40); rd_chk("e_en_glitch_hold", 4, (base + 1) & 255);

        // IFLAG clearing, and clear colliding with a new set
        do_reset();
        setup_ch0();
        wr_reg(8, 'hFF);
        wr_reg(10, 'h0C);
        wr_reg(0, 0);
        step(140);
        check("f_irq_both", 32'(bus.irq), 32'd3);
        wr_reg(1, 1);
        check("f_irq_clr0", 32'(bus.irq), 32'd2);
        check("f_irq_any", 32'(bus.irq_any), 32'd1);
        step(116);
        wr_reg(1, 1);
        check("f_irq_set_wins", 32'(bus.irq), 32'd3);

        // Randomized traffic checked cycle by cycle against the model
        do_reset();
        for (int i = 0; i < 8000; i++) begin
            int r, a, d;
            r = int'($urandom_range(0, 199));
            bus.wr = 1'b0;
            bus.rd = 1'b0;
            if (r == 0) begin
                reset = 1'b1;
            end else if (r < 28) begin
                case ($urandom_range(0, 8))
                    0:       a = (($urandom_range(0, 9) == 0) ? 0 : 1);
                    1, 2:    a = 4 + 4 * int'($urandom_range(0, 1));
                    3:       a = 5 + 4 * int'($urandom_range(0, 1));
                    4, 5:    a = 6 + 4 * int'($urandom_range(0, 1));
                    default: a = int'($urandom_range(0, 63));
                endcase
                d = int'($urandom_range(0, 255));
                if (a == 4 || a == 8) d = int'($urandom_range('hF0, 'hFF));
                if ((a == 6 || a == 10) && $urandom_range(0, 4) != 0) d = d | 4;
                bus.addr  = ADDR_W'(a);
                bus.wdata = DATA_W'(d);
                bus.wr    = 1'b1;
            end else if (r < 160) begin
                a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63))
                                                : 4 + int'($urandom_range(0, 6));
                bus.addr = ADDR_W'(a);
                bus.rd   = 1'b1;
            end
            step(1);
            reset = 1'b0;
        end
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
